// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer slave: register offsets, CTRL bit
// positions, the APB phase type and small counter helpers.
package apb_timer_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_LOAD     = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  localparam int CTRL_ENABLE      = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_phase_e;

  function automatic apb_phase_e apb_phase(input logic sel, input logic enable);
    if (!sel) return IDLE;
    return enable ? ACCESS : SETUP;
  endfunction

  // COUNT stops at zero rather than wrapping.
  function automatic logic [31:0] dec_floor0(input logic [31:0] value);
    return (value == 32'd0) ? 32'd0 : value - 32'd1;
  endfunction

endpackage

// File: rtl/apb_timer_slave_if.sv
// APB signal bundle between the AHB-to-APB bridge (master) and the timer slave.
interface apb_timer_slave_if;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Prdata
  );
endinterface

// File: rtl/apb_timer_core.sv
// Prescaler plus 32-bit down-counter; reports expiry and, in one-shot mode,
// asks the register bank to clear CTRL.enable.
module apb_timer_core
  import apb_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 16,
  parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [31:0]           load,
  input  logic                  count_wr,
  input  logic [31:0]           count_wdata,
  output logic [31:0]           count,
  output logic                  expire,
  output logic                  hw_disable
);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  tick;
  logic                  at_zero;

  assign tick       = enable && (pre_cnt == prescale);
  assign at_zero    = (count == 32'd0);
  assign expire     = tick && at_zero;
  assign hw_disable = expire && !auto_reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (!enable || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRESCALE_W'(1);
    end
  end

  // count_wr and tick never coincide: the copy only happens while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_LOAD;
    end else if (count_wr) begin
      count <= count_wdata;
    end else if (tick) begin
      if (at_zero) begin
        if (auto_reload) count <= load;
      end else begin
        count <= dec_floor0(count);
      end
    end
  end

endmodule

// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB timer slave: address decode, register bank and the
// registered read-data path in front of apb_timer_core.
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter int unsigned SEL_INDEX  = 0,
  parameter int unsigned PRESCALE_W = 16,
  parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  apb_timer_slave_if.slave  bus,
  output logic              timer_irq
);

  logic                  sel;
  apb_phase_e            phase;
  logic [2:0]            reg_sel;
  logic                  wr_en;
  logic                  rd_en;
  logic [2:0]            ctrl;
  logic                  expired;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0]           load;
  logic [31:0]           count;
  logic [31:0]           rdata;
  logic [31:0]           prdata;
  logic                  expire;
  logic                  hw_disable;
  logic                  count_wr;
  logic                  unused_bits;

  assign sel         = bus.Pselx[SEL_INDEX];
  assign phase       = apb_phase(sel, bus.Penable);
  assign reg_sel     = bus.Paddr[4:2];
  assign wr_en       = (phase == ACCESS) && bus.Pwrite;
  assign rd_en       = (phase == SETUP) && !bus.Pwrite;
  assign count_wr    = wr_en && (reg_sel == REG_LOAD) && !ctrl[CTRL_ENABLE];
  assign unused_bits = ^{bus.Pselx, bus.Paddr[31:5], bus.Paddr[1:0]};

  // A bus write to CTRL overrides the one-shot self-disable in the same cycle.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      ctrl <= '0;
    end else if (wr_en && (reg_sel == REG_CTRL)) begin
      ctrl <= bus.Pwdata[2:0];
    end else if (hw_disable) begin
      ctrl[CTRL_ENABLE] <= 1'b0;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      load     <= RESET_LOAD;
      prescale <= '0;
    end else if (wr_en) begin
      if (reg_sel == REG_LOAD)     load     <= bus.Pwdata;
      if (reg_sel == REG_PRESCALE) prescale <= bus.Pwdata[PRESCALE_W-1:0];
    end
  end

  // Expiry has priority over a same-cycle write-1-to-clear.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      expired <= 1'b0;
    end else if (expire) begin
      expired <= 1'b1;
    end else if (wr_en && (reg_sel == REG_STATUS) && bus.Pwdata[0]) begin
      expired <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL:     rdata = {29'd0, ctrl};
      REG_LOAD:     rdata = load;
      REG_COUNT:    rdata = count;
      REG_STATUS:   rdata = {31'd0, expired};
      REG_PRESCALE: rdata = 32'(prescale);
      default:      rdata = '0;
    endcase
  end

  // Captured at the end of setup so data is stable for the whole access phase.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      prdata <= '0;
    end else if (rd_en) begin
      prdata <= rdata;
    end
  end

  assign bus.Prdata = prdata;
  assign timer_irq  = expired & ctrl[CTRL_IRQ_EN];

  apb_timer_core #(
    .PRESCALE_W (PRESCALE_W),
    .RESET_LOAD (RESET_LOAD)
  ) u_core (
    .clk         (Hclk),
    .rst_n       (Hresetn),
    .enable      (ctrl[CTRL_ENABLE]),
    .auto_reload (ctrl[CTRL_AUTO_RELOAD]),
    .prescale    (prescale),
    .load        (load),
    .count_wr    (count_wr),
    .count_wdata (bus.Pwdata),
    .count       (count),
    .expire      (expire),
    .hw_disable  (hw_disable)
  );

endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave: APB stimulus, a closed-form timer model and a
// scoreboard drained by a read-data monitor.
module tb_apb_timer_slave;

  localparam logic [31:0] RESET_LOAD = 32'hFFFF_FFFF;

  logic Hclk = 1'b0;
  logic Hresetn;
  logic timer_irq;

  apb_timer_slave_if bus();

  apb_timer_slave #(
    .SEL_INDEX  (0),
    .PRESCALE_W (16),
    .RESET_LOAD (RESET_LOAD)
  ) dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .bus       (bus),
    .timer_irq (timer_irq)
  );

  always #5 Hclk = ~Hclk;

  longint cyc = 0;
  always @(posedge Hclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_prdata;

  // Timer model: a run starts at the edge the enable write commits; state at
  // any later edge follows from the number of prescaled ticks elapsed.
  logic        run_active, run_auto, run_irq;
  longint      run_e0, run_c0, run_l, run_p, last_exp, last_w1c;
  logic [31:0] m_load, m_count;
  logic [15:0] m_presc;
  logic [2:0]  m_ctrl;

  function automatic void model_reset();
    run_active = 1'b0; run_auto = 1'b0; run_irq = 1'b0;
    run_e0 = 0; run_c0 = 0; run_l = 0; run_p = 0;
    last_exp = -1; last_w1c = -1;
    m_load = RESET_LOAD; m_count = RESET_LOAD; m_presc = '0; m_ctrl = '0;
  endfunction

  function automatic longint ticks_at(input longint e);
    if (e < run_e0) return 0;
    return (e - run_e0) / (run_p + 1);
  endfunction

  function automatic logic [31:0] count_at(input longint e);
    longint t;
    if (!run_active) return m_count;
    t = ticks_at(e);
    if (t <= run_c0) return 32'(run_c0 - t);
    if (!run_auto) return 32'd0;
    return 32'(run_l - ((t - run_c0 - 1) % (run_l + 1)));
  endfunction

  function automatic longint exp_at(input longint e);
    longint t, tk;
    if (!run_active) return last_exp;
    t = ticks_at(e);
    if (t < run_c0 + 1) return last_exp;
    tk = run_auto ? (run_c0 + 1 + ((t - run_c0 - 1) / (run_l + 1)) * (run_l + 1)) : run_c0 + 1;
    return run_e0 + tk * (run_p + 1);
  endfunction

  function automatic logic en_at(input longint e);
    if (!run_active) return m_ctrl[0];
    return run_auto || (e < run_e0 + (run_c0 + 1) * (run_p + 1));
  endfunction

  function automatic logic [2:0] ctrl_at(input longint e);
    if (!run_active) return m_ctrl;
    return {run_irq, run_auto, en_at(e)};
  endfunction

  function automatic logic expired_at(input longint e);
    longint le;
    le = exp_at(e);
    return (le >= 0) && (le >= last_w1c);
  endfunction

  function automatic logic irq_at(input longint e);
    logic [2:0] c;
    c = ctrl_at(e);
    return expired_at(e) & c[2];
  endfunction

  function automatic logic [31:0] read_at(input int idx, input longint e);
    case (idx)
      0:       return {29'd0, ctrl_at(e)};
      1:       return m_load;
      2:       return count_at(e);
      3:       return {31'd0, expired_at(e)};
      4:       return {16'd0, m_presc};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void end_run(input longint c);
    if (run_active) begin
      m_count    = count_at(c);
      last_exp   = exp_at(c);
      m_ctrl     = ctrl_at(c);
      run_active = 1'b0;
    end
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] data, input longint c);
    case (idx)
      0: begin
        end_run(c);
        m_ctrl = data[2:0];
        if (data[0]) begin
          run_active = 1'b1; run_e0 = c; run_c0 = longint'(m_count);
          run_l = longint'(m_load); run_p = longint'(m_presc);
          run_auto = data[1]; run_irq = data[2];
        end
      end
      1: begin
        if (!en_at(c - 1)) begin
          end_run(c);
          m_count = data;
        end
        m_load = data;
      end
      3: if (data[0]) last_w1c = c;
      4: m_presc = data[15:0];
      default: ;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr(input int idx);
    logic [31:0] r;
    r = $urandom;
    return (r & 32'hFFFF_FFE3) | (32'(idx) << 2);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Hclk); #1;
    end
  endtask

  task automatic apb_write(input int idx, input logic [31:0] data);
    longint k = cyc;
    model_write(idx, data, k + 2);
    bus.Pselx = 3'b001; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
    bus.Paddr = rand_addr(idx); bus.Pwdata = data;
    @(posedge Hclk); #1; bus.Penable = 1'b1;
    @(posedge Hclk); #1; bus.Pselx = 3'b000; bus.Penable = 1'b0;
  endtask

  task automatic apb_read(input int idx);
    exp_t   e;
    longint k = cyc;
    e.idx = idx; e.data = read_at(idx, k); e.irq = irq_at(k + 1);
    sb.push_back(e);
    last_prdata = e.data;
    bus.Pselx = 3'b001; bus.Penable = 1'b0; bus.Pwrite = 1'b0;
    bus.Paddr = rand_addr(idx); bus.Pwdata = $urandom;
    @(posedge Hclk); #1; bus.Penable = 1'b1;
    @(posedge Hclk); #1; bus.Pselx = 3'b000; bus.Penable = 1'b0;
  endtask

  task automatic apb_nosel(input int idx, input logic wr, input logic [31:0] data);
    bus.Pselx = 3'b110; bus.Penable = 1'b0; bus.Pwrite = wr;
    bus.Paddr = rand_addr(idx); bus.Pwdata = data;
    @(posedge Hclk); #1; bus.Penable = 1'b1;
    @(posedge Hclk); #1; bus.Pselx = 3'b000; bus.Penable = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] ld, input logic [31:0] ps, input logic [2:0] ctl);
    apb_write(0, 32'd0);
    apb_write(3, 32'd1);
    apb_write(1, ld);
    apb_write(4, ps);
    apb_write(0, {29'd0, ctl});
  endtask

  always @(negedge Hclk) begin
    exp_t e;
    if (Hresetn && bus.Pselx[0] && bus.Penable && !bus.Pwrite) begin
      if (sb.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL sb_underflow: read with no expected entry, Prdata 0x%08h", bus.Prdata);
      end else begin
        e = sb.pop_front();
        check($sformatf("rd[%0d].prdata", e.idx), bus.Prdata, e.data);
        check($sformatf("rd[%0d].irq", e.idx), 32'(timer_irq), 32'(e.irq));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    model_reset();
    last_prdata = '0;
    Hresetn = 1'b0;
    bus.Pselx = '0; bus.Penable = 1'b0; bus.Pwrite = 1'b0; bus.Paddr = '0; bus.Pwdata = '0;
    repeat (3) @(posedge Hclk);
    #1;
    check("reset.prdata", bus.Prdata, 32'd0);
    check("reset.irq", 32'(timer_irq), 32'd0);
    Hresetn = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) apb_read(i);

    // register bank while disabled
    r = $urandom; apb_write(1, r); apb_read(1); apb_read(2);
    r = $urandom; apb_write(4, r); apb_read(4);
    r = $urandom & 32'hFFFF_FFFE; apb_write(0, r); apb_read(0);
    for (int i = 5; i < 8; i++) begin
      apb_write(i, $urandom); apb_read(i);
    end

    // unselected transfers and a COUNT write leave everything untouched
    apb_read(1);
    apb_nosel(1, 1'b1, 32'h0000_1234);
    apb_nosel(0, 1'b0, 32'd0);
    check("nosel.prdata_hold", bus.Prdata, last_prdata);
    apb_write(2, 32'h0BAD_0BAD);
    apb_read(1); apb_read(2);

    // one-shot, LOAD=3 PRESCALE=0; two passes shifted by one cycle
    for (int d = 0; d < 2; d++) begin
      start_run(32'd3, 32'd0, 3'b101);
      idle(d);
      apb_read(2); apb_read(2); apb_read(3); apb_read(0);
    end

    // auto-reload, LOAD=2 PRESCALE=1
    start_run(32'd2, 32'd1, 3'b011);
    for (int i = 0; i < 10; i++) apb_read((i % 2 == 0) ? 2 : 3);

    // W1C landing on the expiry edge, then a second W1C
    start_run(32'd3, 32'd0, 3'b101);
    idle(2);
    apb_write(3, 32'd1);
    check("w1c_on_expiry.irq", 32'(timer_irq), 32'(irq_at(cyc)));
    check("w1c_on_expiry.irq_high", 32'(timer_irq), 32'd1);
    apb_write(3, 32'd1);
    check("w1c_second.irq", 32'(timer_irq), 32'd0);
    apb_read(3);

    // randomized runs
    for (int run = 0; run < 8; run++) begin
      start_run($urandom_range(0, 5), $urandom_range(0, 3),
                {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1});
      for (int j = 0; j < 10; j++) begin
        int op;
        idle($urandom_range(0, 3));
        op = $urandom_range(0, 9);
        if (op < 7)       apb_read($urandom_range(0, 7));
        else if (op == 7) apb_write(($urandom_range(0, 1) == 1) ? 2 : $urandom_range(5, 7), $urandom);
        else if (op == 8) apb_write(3, $urandom);
        else              apb_read(2);
      end
    end

    // reset between setup and access of a LOAD write
    start_run(32'd0, 32'd0, 3'b101);
    idle(3);
    check("pre_reset.irq", 32'(timer_irq), 32'(irq_at(cyc)));
    apb_read(3);
    bus.Pselx = 3'b001; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
    bus.Paddr = rand_addr(1); bus.Pwdata = 32'h1234_5678;
    @(posedge Hclk); #1;
    Hresetn = 1'b0;
    #1;
    model_reset();
    last_prdata = '0;
    check("midreset.prdata", bus.Prdata, 32'd0);
    check("midreset.irq", 32'(timer_irq), 32'd0);
    bus.Penable = 1'b1;
    @(posedge Hclk); #1;
    bus.Pselx = 3'b000; bus.Penable = 1'b0;
    @(posedge Hclk); #1;
    Hresetn = 1'b1;
    idle(1);
    for (int i = 0; i < 5; i++) apb_read(i);

    idle(2);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
